// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the serial pattern generator and its detector.
// Holds the FSM state encoding, default width constants and the idle line level.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_LEN_W = 4;
    localparam int unsigned DEF_GAP_W = 4;
    localparam int unsigned DEF_REP_W = 4;

    // Level driven on the serial line whenever no pattern bit is being sent.
    localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable non-wrapping down-counter with zero flag.
// Ports:
//   CLK, RST  - clock, asynchronous active-low reset
//   load      - load load_val (has priority over dec)
//   dec       - decrement by one; holds at zero
//   load_val  - value loaded on load
//   cnt       - registered count
//   zero_c    - combinational flag, high when cnt is zero
module seq_down_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         zero_c
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial pattern generator: shifts a latched pattern MSB-first onto Out1,
// repeated Reps+1 times with Gap idle cycles between repetitions.
// Ports:
//   CLK, RST  - clock, asynchronous active-low reset
//   Start     - transfer request, accepted only in IDLE
//   Pattern   - bits to send (latched on accepted Start)
//   Len       - bits per repetition; 0 or >WIDTH means WIDTH
//   Reps      - extra repetitions
//   Gap       - idle cycles between repetitions
//   Out1      - registered serial data
//   Busy      - registered, high while sending or in a gap
//   Done      - registered one-cycle completion pulse
module fsm_seq_gen
    import fsm_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned GAP_W = DEF_GAP_W,
    parameter int unsigned REP_W = DEF_REP_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [LEN_W-1:0] Len,
    input  logic [REP_W-1:0] Reps,
    input  logic [GAP_W-1:0] Gap,
    output logic             Out1,
    output logic             Busy,
    output logic             Done
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             out1_d, busy_d, done_d;

    logic             bit_load, bit_dec, bit_zero;
    logic [LEN_W-1:0] bit_val, bit_cnt;
    logic             gap_load, gap_dec, gap_zero;
    logic [GAP_W-1:0] gap_val, gap_cnt;
    logic             rep_load, rep_dec, rep_zero;
    logic [REP_W-1:0] rep_val, rep_cnt;

    logic [LEN_W-1:0] len_cl;
    logic             new_first_bit, first_bit, next_bit;

    assign len_cl = ((Len == '0) || (Len > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : Len;

    // Candidate output bits: first bit of a new request, first bit of a
    // repetition from the latch, and the bit after the current index.
    assign new_first_bit = 1'(Pattern >> (len_cl - LEN_W'(1)));
    assign first_bit     = 1'(pat_q >> (len_q - LEN_W'(1)));
    assign next_bit      = 1'(pat_q >> (bit_cnt - LEN_W'(1)));

    seq_down_cnt #(.W(LEN_W)) u_bit_cnt (
        .CLK(CLK), .RST(RST), .load(bit_load), .dec(bit_dec),
        .load_val(bit_val), .cnt(bit_cnt), .zero_c(bit_zero)
    );

    seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .CLK(CLK), .RST(RST), .load(gap_load), .dec(gap_dec),
        .load_val(gap_val), .cnt(gap_cnt), .zero_c(gap_zero)
    );

    seq_down_cnt #(.W(REP_W)) u_rep_cnt (
        .CLK(CLK), .RST(RST), .load(rep_load), .dec(rep_dec),
        .load_val(rep_val), .cnt(rep_cnt), .zero_c(rep_zero)
    );

    // Next-state, latch and next-output logic; outputs are registered below.
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        gap_d    = gap_q;
        out1_d   = IDLE_LEVEL;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        bit_load = 1'b0;
        bit_dec  = 1'b0;
        bit_val  = len_q - LEN_W'(1);
        gap_load = 1'b0;
        gap_dec  = 1'b0;
        gap_val  = gap_q - GAP_W'(1);
        rep_load = 1'b0;
        rep_dec  = 1'b0;
        rep_val  = Reps;

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_SEND;
                    pat_d    = Pattern;
                    len_d    = len_cl;
                    gap_d    = Gap;
                    bit_load = 1'b1;
                    bit_val  = len_cl - LEN_W'(1);
                    rep_load = 1'b1;
                    out1_d   = new_first_bit;
                    busy_d   = 1'b1;
                end
            end
            ST_SEND: begin
                busy_d = 1'b1;
                if (!bit_zero) begin
                    bit_dec = 1'b1;
                    out1_d  = next_bit;
                end else if (rep_zero) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_q != '0) begin
                    // Gap counter runs Gap-1..0 so the line idles exactly Gap cycles.
                    state_d  = ST_GAP;
                    rep_dec  = 1'b1;
                    gap_load = 1'b1;
                end else begin
                    // Zero gap: restart at the top bit with no idle bubble.
                    rep_dec  = 1'b1;
                    bit_load = 1'b1;
                    out1_d   = first_bit;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (gap_zero) begin
                    state_d  = ST_SEND;
                    bit_load = 1'b1;
                    out1_d   = first_bit;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            gap_q   <= '0;
            Out1    <= IDLE_LEVEL;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            Out1    <= out1_d;
            Busy    <= busy_d;
            Done    <= done_d;
        end
    end

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Self-checking bench for fsm_seq_gen: directed vector table, reset/ignored
// input sequences, and randomized transfers against a queue-based model.
module tb_fsm_seq_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;
    localparam int unsigned GAP_W = 4;
    localparam int unsigned REP_W = 4;

    logic             CLK;
    logic             RST;
    logic             Start;
    logic [WIDTH-1:0] Pattern;
    logic [LEN_W-1:0] Len;
    logic [REP_W-1:0] Reps;
    logic [GAP_W-1:0] Gap;
    logic             Out1;
    logic             Busy;
    logic             Done;

    int checks = 0;
    int errors = 0;

    // Expected serial stream of the current transfer, first bit at the front.
    logic exp_q[$];

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  reps;
        logic [3:0]  gap;
        logic [15:0] bits;   // expected stream, bits[n-1] sent first
        int          n;
    } vec_t;

    vec_t vecs[5];

    fsm_seq_gen #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .GAP_W(GAP_W), .REP_W(REP_W)
    ) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Pattern(Pattern), .Len(Len),
        .Reps(Reps), .Gap(Gap), .Out1(Out1), .Busy(Busy), .Done(Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_out(input string name, input logic e_out, input logic e_busy,
                             input logic e_done);
        checks++;
        if ({Out1, Busy, Done} !== {e_out, e_busy, e_done}) begin
            errors++;
            $display("FAIL %s: Out1/Busy/Done got %b%b%b, expected %b%b%b",
                     name, Out1, Busy, Done, e_out, e_busy, e_done);
        end
    endtask

    // Reference: concatenate clamped-length MSB-first slices with gap zeros.
    task automatic model_build(input logic [7:0] pat, input logic [3:0] len,
                               input logic [3:0] reps, input logic [3:0] gap);
        int l;
        exp_q.delete();
        l = ((len == 4'd0) || (int'(len) > int'(WIDTH))) ? int'(WIDTH) : int'(len);
        for (int r = 0; r <= int'(reps); r++) begin
            for (int i = l - 1; i >= 0; i--) exp_q.push_back(pat[i]);
            if (r < int'(reps))
                for (int g = 0; g < int'(gap); g++) exp_q.push_back(1'b0);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the idle cycle after Done.
    task automatic run_xfer(input string name, input logic [7:0] pat, input logic [3:0] len,
                            input logic [3:0] reps, input logic [3:0] gap, input bit disturb);
        Start   = 1'b1;
        Pattern = pat;
        Len     = len;
        Reps    = reps;
        Gap     = gap;
        @(negedge CLK);
        Start   = 1'b0;
        // Inputs changed after acceptance must have no effect.
        Pattern = WIDTH'($urandom);
        Len     = LEN_W'($urandom);
        Reps    = REP_W'($urandom);
        Gap     = GAP_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (disturb && i == 1) begin
                Start   = 1'b1;
                Pattern = 8'hFF;
            end
            check_out($sformatf("%s bit%0d", name, i), exp_q[i], 1'b1, 1'b0);
            @(negedge CLK);
        end
        check_out($sformatf("%s done", name), 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        Start = 1'b0;
        check_out($sformatf("%s idle", name), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{pat: 8'h0A, len: 4'd4, reps: 4'd0, gap: 4'd0, bits: 16'b1010, n: 4};
        vecs[1] = '{pat: 8'h02, len: 4'd2, reps: 4'd2, gap: 4'd3, bits: 16'b100001000010, n: 12};
        vecs[2] = '{pat: 8'hA5, len: 4'd0, reps: 4'd0, gap: 4'd0, bits: 16'b10100101, n: 8};
        vecs[3] = '{pat: 8'hA5, len: 4'd9, reps: 4'd0, gap: 4'd0, bits: 16'b10100101, n: 8};
        vecs[4] = '{pat: 8'h01, len: 4'd1, reps: 4'd1, gap: 4'd0, bits: 16'b11, n: 2};

        RST     = 1'b1;
        Start   = 1'b0;
        Pattern = '0;
        Len     = '0;
        Reps    = '0;
        Gap     = '0;
        #1 RST = 1'b0;
        #1 check_out("reset", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        check_out("reset released", 1'b0, 1'b0, 1'b0);

        // Directed table; back-to-back starts at the earliest legal cycle.
        for (int v = 0; v < 5; v++) begin
            exp_q.delete();
            for (int i = vecs[v].n - 1; i >= 0; i--) exp_q.push_back(vecs[v].bits[i]);
            run_xfer($sformatf("vec%0d", v), vecs[v].pat, vecs[v].len, vecs[v].reps,
                     vecs[v].gap, 1'b0);
        end

        // Start and Pattern change during SEND are ignored; exactly one transfer.
        exp_q.delete();
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        run_xfer("ignored", 8'h0A, 4'd4, 4'd0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_out($sformatf("ignored after%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-SEND: outputs clear asynchronously, no Done afterwards.
        Start   = 1'b1;
        Pattern = 8'hFF;
        Len     = 4'd8;
        Reps    = 4'd1;
        Gap     = 4'd2;
        @(negedge CLK);
        Start = 1'b0;
        repeat (2) @(negedge CLK);
        check_out("pre reset", 1'b1, 1'b1, 1'b0);
        #1 RST = 1'b0;
        #1 check_out("async reset", 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge CLK);
        check_out("reset held", 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge CLK);
            check_out($sformatf("post reset%0d", i), 1'b0, 1'b0, 1'b0);
        end

        // Randomized transfers against the model.
        for (int t = 0; t < 40; t++) begin
            logic [7:0] p;
            logic [3:0] l, r, g;
            p = 8'($urandom);
            l = 4'($urandom_range(0, 15));
            r = 4'($urandom_range(0, 3));
            g = 4'($urandom_range(0, 3));
            model_build(p, l, r, g);
            run_xfer($sformatf("rand%0d p=%h l=%0d r=%0d g=%0d", t, p, l, r, g),
                     p, l, r, g, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
